// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and enums for the memory port arbiter (package arb_pkg).
package arb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 4;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    typedef enum logic {
        PORT_CPU,
        PORT_DMA
    } port_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU, DMA and RAM-side signals of the memory port arbiter.
interface mem_port_arbiter_if;
    import arb_pkg::*;

    logic              cpu_req;
    logic              cpu_w;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_w;
    logic [ADDR_W-1:0] dma_addr;
    logic [LEN_W-1:0]  dma_len;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_done;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_r;
    logic              mem_w;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_w, cpu_addr, cpu_wdata,
        input  dma_req, dma_w, dma_addr, dma_len, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_done, dma_rvalid, dma_rdata,
        output mem_addr, mem_r, mem_w, mem_wdata
    );

    // Requester / RAM side
    modport master (
        output cpu_req, cpu_w, cpu_addr, cpu_wdata,
        output dma_req, dma_w, dma_addr, dma_len, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_done, dma_rvalid, dma_rdata,
        input  mem_addr, mem_r, mem_w, mem_wdata
    );

endinterface

// File: rtl/mem_burst_ctr.sv
// DMA burst beat counter: latches base/len on beat 0 and produces the
// wrapped beat address plus a final-beat flag for the following beats.
module mem_burst_ctr
    import arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;

    // Beat 0 is consumed in the start cycle, so the count resumes at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            base_q <= base;
            len_q  <= len;
            cnt_q  <= (len == '0) ? '0 : LEN_W'(1);
        end else if (step) begin
            cnt_q  <= last ? '0 : cnt_q + 1'b1;
        end
    end

    assign addr = base_q + ADDR_W'(cnt_q);
    assign last = (cnt_q == len_q);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between a CPU word port and a DMA burst port.
// Define ARB_RR_EN for round-robin tie breaking; default is CPU priority.
module mem_port_arbiter
    import arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    port_e             prio;
    logic              in_idle;
    logic              cpu_win;
    logic              cpu_gnt, dma_gnt, dma_done;
    logic              abort, start, step;
    logic              ctr_clr;
    logic [ADDR_W-1:0] burst_addr;
    logic              burst_last;
    logic              dma_w_q;
    logic              dma_w_eff;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_r, mem_w;
    logic              cpu_rd_p0, dma_rd_p0;
    logic              cpu_rvalid_p1, dma_rvalid_p1;
    logic [DATA_W-1:0] cpu_rdata_p1, dma_rdata_p1;

    assign in_idle = (state_q == IDLE);

`ifdef ARB_RR_EN
    port_e prio_q;

    // Priority goes to whichever port was not granted most recently
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PORT_CPU;
        end else if (cpu_gnt) begin
            prio_q <= PORT_DMA;
        end else if (dma_gnt || abort) begin
            prio_q <= PORT_CPU;
        end
    end

    assign prio = prio_q;
`else
    assign prio = PORT_CPU;
`endif

    assign cpu_win = bus.cpu_req && (!bus.dma_req || (prio == PORT_CPU));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cpu_gnt  = 1'b0;
        dma_gnt  = 1'b0;
        dma_done = 1'b0;
        abort    = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (cpu_win) begin
                        cpu_gnt = 1'b1;
                    end else if (bus.dma_req) begin
                        dma_gnt = 1'b1;
                        start   = 1'b1;
                        if (bus.dma_len == '0) begin
                            dma_done = 1'b1;
                        end else begin
                            state_d = BURST;
                        end
                    end
                end
                BURST: begin
                    if (bus.dma_req) begin
                        dma_gnt = 1'b1;
                        step    = 1'b1;
                        if (burst_last) begin
                            dma_done = 1'b1;
                            state_d  = IDLE;
                        end
                    end else begin
                        abort   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ctr_clr = rst || abort;

    mem_burst_ctr u_ctr (
        .clk   (clk),
        .rst   (ctr_clr),
        .start (start),
        .step  (step),
        .base  (bus.dma_addr),
        .len   (bus.dma_len),
        .addr  (burst_addr),
        .last  (burst_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dma_w_q <= 1'b0;
        end else if (start) begin
            dma_w_q <= bus.dma_w;
        end
    end

    // Direction comes live from the port on beat 0, latched afterwards
    assign dma_w_eff = in_idle ? bus.dma_w : dma_w_q;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        if (cpu_gnt) begin
            mem_addr = bus.cpu_addr;
            mem_r    = !bus.cpu_w;
            mem_w    = bus.cpu_w;
            if (bus.cpu_w) begin
                mem_wdata = bus.cpu_wdata;
            end
        end else if (dma_gnt) begin
            mem_addr = in_idle ? bus.dma_addr : burst_addr;
            mem_r    = !dma_w_eff;
            mem_w    = dma_w_eff;
            if (dma_w_eff) begin
                mem_wdata = bus.dma_wdata;
            end
        end
    end

    assign cpu_rd_p0 = cpu_gnt && !bus.cpu_w;
    assign dma_rd_p0 = dma_gnt && !dma_w_eff;

    // Read return stage: capture RAM data one cycle after the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_p1 <= 1'b0;
            dma_rvalid_p1 <= 1'b0;
            cpu_rdata_p1  <= '0;
            dma_rdata_p1  <= '0;
        end else begin
            cpu_rvalid_p1 <= cpu_rd_p0;
            dma_rvalid_p1 <= dma_rd_p0;
            if (cpu_rd_p0) begin
                cpu_rdata_p1 <= bus.mem_rdata;
            end
            if (dma_rd_p0) begin
                dma_rdata_p1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.dma_done   = dma_done;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_r      = mem_r;
    assign bus.mem_w      = mem_w;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.cpu_rvalid = cpu_rvalid_p1;
    assign bus.cpu_rdata  = cpu_rdata_p1;
    assign bus.dma_rvalid = dma_rvalid_p1;
    assign bus.dma_rdata  = dma_rdata_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level model feeds
// expected grants and read data; a negedge monitor compares them.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    typedef struct {
        bit                dma;
        logic [ADDR_W-1:0] addr;
        bit                w;
        logic [DATA_W-1:0] wdata;
        bit                done;
        int                at;
    } gnt_t;

    typedef struct {
        logic [DATA_W-1:0] d;
        int                at;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] ram     [0:4095];
    logic [DATA_W-1:0] ref_mem [0:4095];
    gnt_t gnt_q[$];
    rd_t  cpu_rd_q[$];
    rd_t  dma_rd_q[$];
    int   nchecks = 0;
    int   nerrors = 0;

    function automatic logic [DATA_W-1:0] init_val(input int a);
        return 16'(a * 37) ^ 16'hA5C3;
    endfunction

    // RAM model: combinational read, write applied mid-cycle
    assign bus.mem_rdata = (bus.mem_r === 1'b1) ? ram[bus.mem_addr] : '0;

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = init_val(a);
        ram[12'h010] = 16'hBEEF;
        forever begin
            @(negedge clk);
            if (bus.mem_w === 1'b1) ram[bus.mem_addr] = bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    always @(negedge clk) begin
        gnt_t e;
        rd_t  r;
        logic g_cpu, g_dma;
        g_cpu = (bus.cpu_gnt === 1'b1);
        g_dma = (bus.dma_gnt === 1'b1);
        check("gnt_exclusive", 32'(g_cpu & g_dma), 0);
        if (g_cpu || g_dma) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_gnt", {g_cpu, g_dma}, 0);
            end else begin
                e = gnt_q.pop_front();
                check("gnt_cycle", cyc_n, e.at);
                check("gnt_port_dma", g_dma, e.dma);
                check("mem_addr", bus.mem_addr, e.addr);
                check("mem_w", bus.mem_w, e.w);
                check("mem_r", bus.mem_r, !e.w);
                if (e.w) check("mem_wdata", bus.mem_wdata, e.wdata);
                check("dma_done", bus.dma_done, e.done);
            end
        end else begin
            check("idle_bus", {bus.mem_r, bus.mem_w, bus.dma_done, bus.mem_addr, bus.mem_wdata}, 0);
            if (gnt_q.size() != 0 && gnt_q[0].at <= cyc_n) begin
                e = gnt_q.pop_front();
                check("gnt_present", {g_cpu, g_dma}, e.dma ? 1 : 2);
            end
        end
        if (bus.cpu_rvalid === 1'b1) begin
            if (cpu_rd_q.size() == 0) begin
                check("unexpected_cpu_rvalid", bus.cpu_rvalid, 0);
            end else begin
                r = cpu_rd_q.pop_front();
                check("cpu_rvalid_cycle", cyc_n, r.at);
                check("cpu_rdata", bus.cpu_rdata, r.d);
            end
        end else if (cpu_rd_q.size() != 0 && cpu_rd_q[0].at <= cyc_n) begin
            r = cpu_rd_q.pop_front();
            check("cpu_rvalid", bus.cpu_rvalid, 1);
        end
        if (bus.dma_rvalid === 1'b1) begin
            if (dma_rd_q.size() == 0) begin
                check("unexpected_dma_rvalid", bus.dma_rvalid, 0);
            end else begin
                r = dma_rd_q.pop_front();
                check("dma_rvalid_cycle", cyc_n, r.at);
                check("dma_rdata", bus.dma_rdata, r.d);
            end
        end else if (dma_rd_q.size() != 0 && dma_rd_q[0].at <= cyc_n) begin
            r = dma_rd_q.pop_front();
            check("dma_rvalid", bus.dma_rvalid, 1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cpu(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        gnt_q.push_back('{dma: 1'b0, addr: a, w: w, wdata: d, done: 1'b0, at: cyc_n});
        if (w) ref_mem[a] = d;
        else cpu_rd_q.push_back('{d: ref_mem[a], at: cyc_n + 1});
    endtask

    task automatic exp_dma(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit done);
        gnt_q.push_back('{dma: 1'b1, addr: a, w: w, wdata: d, done: done, at: cyc_n});
        if (w) ref_mem[a] = d;
        else dma_rd_q.push_back('{d: ref_mem[a], at: cyc_n + 1});
    endtask

    task automatic cpu_drive(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_w     = w;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic cpu_op(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_drive(w, a, d);
        exp_cpu(w, a, d);
        cyc();
        bus.cpu_req = 1'b0;
    endtask

    // One beat; after beat 0 the sampled-at-start fields are scrambled
    task automatic dma_beat(input bit w, input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                            input int i, input logic [DATA_W-1:0] d);
        bus.dma_req = 1'b1;
        if (i == 0) begin
            bus.dma_w    = w;
            bus.dma_addr = base;
            bus.dma_len  = len;
        end else begin
            bus.dma_w    = 1'($urandom);
            bus.dma_addr = 12'($urandom);
            bus.dma_len  = 4'($urandom);
        end
        bus.dma_wdata = d;
        exp_dma(w, base + 12'(i), d, i == int'(len));
    endtask

    task automatic dma_burst(input bit w, input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                             input int abort_at, input bit seq);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_at) begin
                bus.dma_req = 1'b0;
                cyc();
                return;
            end
            dma_beat(w, base, len, i, seq ? 16'(i + 1) : 16'($urandom));
            cyc();
        end
        bus.dma_req = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        bus.cpu_req = 0; bus.cpu_w = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_w = 0; bus.dma_addr = 0; bus.dma_len = 0; bus.dma_wdata = 0;
        for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(a);
        ref_mem[12'h010] = 16'hBEEF;

        // Reset state, with requests asserted to show reset overrides them
        bus.cpu_req = 1'b1;
        bus.dma_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {bus.cpu_gnt, bus.dma_gnt, bus.dma_done, bus.mem_r, bus.mem_w}, 0);
        check("rst_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_dma_rdata", bus.dma_rdata, 0);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        cyc();
        rst = 1'b0;

        // CPU read of preloaded word
        cpu_op(1'b0, 12'h010, 16'h0);
        cyc();

        // Wrapping DMA write burst
        dma_burst(1'b1, 12'hFFE, 4'd3, -1, 1'b1);
        cyc();
        check("ram_ffe", ram[12'hFFE], 16'd1);
        check("ram_fff", ram[12'hFFF], 16'd2);
        check("ram_000", ram[12'h000], 16'd3);
        check("ram_001", ram[12'h001], 16'd4);

        // Tie arbitration from a known pointer
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            cpu_drive(1'b0, 12'h100 + 12'(i), 16'h0);
            bus.dma_req  = 1'b1;
            bus.dma_w    = 1'b0;
            bus.dma_addr = 12'h400;
            bus.dma_len  = 4'd0;
`ifdef ARB_RR_EN
            if (i == 1) exp_dma(1'b0, 12'h400, 16'h0, 1'b1);
            else exp_cpu(1'b0, 12'h100 + 12'(i), 16'h0);
`else
            exp_cpu(1'b0, 12'h100 + 12'(i), 16'h0);
`endif
            cyc();
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        cyc();

        // CPU lockout during a 16-beat read burst
        for (int i = 0; i <= 16; i++) begin
            if (i <= 15) dma_beat(1'b0, 12'h200, 4'd15, i, 16'($urandom));
            else bus.dma_req = 1'b0;
            if (i >= 5) cpu_drive(1'b0, 12'h050, 16'h0);
            if (i == 16) exp_cpu(1'b0, 12'h050, 16'h0);
            @(negedge clk);
            check("lockout_cpu_gnt", bus.cpu_gnt, 32'(i == 16));
            cyc();
        end
        bus.cpu_req = 1'b0;
        cyc();

        // Abort at beat 2, then a new burst over the same region
        dma_burst(1'b1, 12'h500, 4'd7, 2, 1'b0);
        dma_burst(1'b0, 12'h4FE, 4'd4, -1, 1'b0);
        cyc();

        // Reset in the middle of a read burst
        for (int i = 0; i < 4; i++) begin
            dma_beat(1'b0, 12'h300, 4'd7, i, 16'h0);
            cyc();
        end
        rst = 1'b1;
        bus.dma_req = 1'b1;
        cpu_drive(1'b0, 12'h060, 16'h0);
        @(negedge clk);
        check("midrst_outputs", {bus.cpu_gnt, bus.dma_gnt, bus.dma_done, bus.mem_r, bus.mem_w}, 0);
        cyc();
        rst = 1'b0;
        bus.dma_req = 1'b0;
        exp_cpu(1'b0, 12'h060, 16'h0);
        @(negedge clk);
        check("post_rst_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
        check("post_rst_dma_rdata", bus.dma_rdata, 0);
        cyc();
        bus.cpu_req = 1'b0;

        // Randomized sequential traffic
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: cpu_op(1'b0, 12'($urandom), 16'h0);
                1: cpu_op(1'b1, 12'($urandom), 16'($urandom));
                2: dma_burst(1'($urandom), 12'($urandom), 4'($urandom), -1, 1'b0);
                default: dma_burst(1'($urandom), 12'($urandom), 4'($urandom),
                                   int'($urandom_range(1, 6)), 1'b0);
            endcase
            repeat ($urandom_range(0, 2)) cyc();
        end

        repeat (3) cyc();
        check("gnt_q_empty", gnt_q.size(), 0);
        check("cpu_rd_q_empty", cpu_rd_q.size(), 0);
        check("dma_rd_q_empty", dma_rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
